irig_frame_ctrl: RTL and testbench
==================================

IRIG_FRAME_CTRL -- requirements
Module: irig_frame_ctrl

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames required to assert locked (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 600000: clk cycles without sym_vld that count as symbol loss (12 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sym_vld  input  1  one-cycle strobe, one per decoded IRIG-B symbol.
REQ-006 SHALL have port sym_type  input  2  symbol class, valid with sym_vld: 00 = "0", 01 = "1", 10 = P marker, 11 = invalid.
REQ-007 SHALL have port frame_vld  output  1  one-cycle pulse when frame_data is updated.
REQ-008 SHALL have port frame_data  output  100  bit i = 1 if frame symbol i was "1"; marker positions read 0.
REQ-009 SHALL have port locked  output  1  frame alignment held.
REQ-010 SHALL have port state  output  2  current FSM state encoding.
REQ-011 SHALL have port err_cnt  output  8  saturating count of frame errors.

Function
REQ-012 SHALL implement the FSM states HUNT = 00, ARM = 01 and RECV = 10; encoding 11 SHALL be unreachable and SHALL recover to HUNT.
REQ-013 HUNT: on sym_vld with P SHALL go to ARM; any other symbol SHALL stay in HUNT.
REQ-014 ARM: on sym_vld with P (the Pr reference) SHALL go to RECV with symbol index = 1; on any other symbol SHALL return to HUNT, with no err_cnt change.
REQ-015 RECV: the 7-bit index SHALL advance by 1 on each sym_vld and wrap from 99 to 0; index 0 is Pr.
REQ-016 Marker positions SHALL be 0, 9, 19, 29, 39, 49, 59, 69, 79, 89 and 99; a marker position requires P.
REQ-017 Frame error: a non-P symbol at a marker position, a P at a non-marker position, or type 11 at any position; on error the block SHALL increment err_cnt (saturate at 255), clear locked and the good-frame counter, and go to HUNT.
REQ-018 Data symbols SHALL shift into an internal 100-bit capture register at their index position.
REQ-019 On a valid index-99 symbol, the block SHALL copy the capture register to frame_data and pulse frame_vld exactly 1 cycle after that sym_vld cycle.
REQ-020 On a valid index-99 symbol, the block SHALL increment the good-frame counter (saturating at LOCK_FRAMES).
REQ-021 locked SHALL assert in the same cycle as the frame_vld that makes the good count reach LOCK_FRAMES.
REQ-022 After index 99, the block SHALL stay in RECV expecting the next Pr at index 0; the first frame after ARM SHALL be complete, since ARM consumed Pr.
REQ-023 frame_vld SHALL pulse for every valid frame, locked or not.
REQ-024 frame_data SHALL hold its value between frame_vld pulses and SHALL never change on error.
REQ-025 Only sym_vld cycles SHALL change the state or the index; sym_type SHALL be ignored when sym_vld = 0.

Reset
REQ-026 While rst_n = 0, the block SHALL asynchronously set state = HUNT, index = 0, frame_vld = 0, frame_data = 0, locked = 0, err_cnt = 0, the good-frame counter to 0 and the capture register to 0.
REQ-027 The block SHALL leave reset synchronously on the first clk edge after rst_n rises.
REQ-028 Reset mid-frame SHALL discard the partial frame, and the block SHALL then resume in HUNT.

Configuration
REQ-029 The macro IRIG_FRAME_TIMEOUT_EN, when defined, SHALL enable a symbol watchdog counter that clears on every sym_vld.
REQ-030 With IRIG_FRAME_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYC in ARM or RECV, the block SHALL treat it as a frame error per REQ-017 and clear the counter.
REQ-031 With IRIG_FRAME_TIMEOUT_EN defined: if sym_vld and the timeout coincide, sym_vld SHALL win, with no error.
REQ-032 With IRIG_FRAME_TIMEOUT_EN defined: in HUNT the timeout SHALL have no effect.
REQ-033 Without IRIG_FRAME_TIMEOUT_EN, the block SHALL contain no watchdog logic, and a stalled symbol stream SHALL hold the current state indefinitely.

Verification
REQ-034 Scenario: reset, then P,P, then 99 symbols forming a valid frame with data "1" at index 1 -> frame_vld pulse, frame_data[1] = 1, frame_data[0] = 0, locked = 0.
REQ-035 Scenario: two back-to-back valid frames with LOCK_FRAMES = 2 -> locked rises with the second frame_vld; state = 10 throughout.
REQ-036 Scenario: while locked, send "0" at index 49 -> err_cnt = 1, locked = 0, state = 00, frame_data unchanged.
REQ-037 Scenario: 260 injected frame errors -> err_cnt saturates at 255.
REQ-038 Scenario: with IRIG_FRAME_TIMEOUT_EN and TIMEOUT_CYC = 1000, stop sym_vld in RECV for 1000 cycles -> state = 00, err_cnt + 1; repeat without the macro -> state stays 10.
REQ-039 Scenario: assert rst_n = 0 at index 50 -> all outputs return to their reset values immediately; a following P,P and valid frame is decoded normally.

Source files
------------

// File: rtl/irig_frame_if.sv
// Symbol-in / frame-out bundle for irig_frame_ctrl.
// sym_vld is a one-cycle strobe with no backpressure; sym_type is only meaningful while sym_vld = 1.
interface irig_frame_if;
  logic         sym_vld;
  logic [1:0]   sym_type;
  logic         frame_vld;
  logic [99:0]  frame_data;
  logic         locked;
  logic [1:0]   state;
  logic [7:0]   err_cnt;

  modport master (
    output sym_vld, sym_type,
    input  frame_vld, frame_data, locked, state, err_cnt
  );

  modport slave (
    input  sym_vld, sym_type,
    output frame_vld, frame_data, locked, state, err_cnt
  );
endinterface

// File: rtl/irig_frame_ctrl.sv
// IRIG-B frame aligner: hunts for the P,Pr pair, captures 100-symbol frames, tracks lock and errors.
// Optional symbol watchdog enabled by defining IRIG_FRAME_TIMEOUT_EN.
module irig_frame_ctrl #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT_CYC = 600000
) (
  input logic         clk,
  input logic         rst_n,
  irig_frame_if.slave bus
);

  localparam logic [1:0] ST_HUNT = 2'b00;
  localparam logic [1:0] ST_ARM  = 2'b01;
  localparam logic [1:0] ST_RECV = 2'b10;

  localparam logic [1:0] SYM_INV = 2'b11;
  localparam logic [1:0] SYM_P   = 2'b10;

  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [6:0] IDX_END = 7'd99;

  logic [1:0]  state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [99:0] cap_q, cap_d;
  logic [99:0] fdata_q, fdata_d;
  logic        fvld_q, fvld_d;
  logic        locked_q, locked_d;
  logic [7:0]  err_q, err_d;
  logic [3:0]  good_q, good_d;
  logic        frame_err;
  logic        sym_p;
  logic        at_marker;

  // Pr sits at index 0; every other marker lands on an index ending in 9.
  function automatic logic is_marker(input logic [6:0] i);
    return (i == 7'd0) || ((i % 7'd10) == 7'd9);
  endfunction

  assign sym_p     = (bus.sym_type == SYM_P);
  assign at_marker = is_marker(idx_q);

`ifdef IRIG_FRAME_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        wd_hit;

  // A symbol in the same cycle as the expiry wins, so the strobe gates the hit.
  always_comb begin
    wd_hit = 1'b0;
    wd_d   = wd_q + 32'd1;
    if (bus.sym_vld) begin
      wd_d = '0;
    end else if (wd_q == 32'(TIMEOUT_CYC - 1)) begin
      wd_d   = '0;
      wd_hit = (state_q == ST_ARM) || (state_q == ST_RECV);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    fdata_d   = fdata_q;
    fvld_d    = 1'b0;
    locked_d  = locked_q;
    err_d     = err_q;
    good_d    = good_q;
    frame_err = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (bus.sym_vld && sym_p) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.sym_vld) begin
          if (sym_p) begin
            state_d = ST_RECV;
            idx_d   = 7'd1;
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_RECV: begin
        if (bus.sym_vld) begin
          if ((bus.sym_type == SYM_INV) || (at_marker != sym_p)) begin
            frame_err = 1'b1;
          end else begin
            if (!sym_p) cap_d[idx_q] = bus.sym_type[0];
            if (idx_q == IDX_END) begin
              idx_d   = 7'd0;
              fdata_d = cap_q;
              fvld_d  = 1'b1;
              if (good_q != LOCK_N) good_d = good_q + 4'd1;
              if (good_d == LOCK_N) locked_d = 1'b1;
            end else begin
              idx_d = idx_q + 7'd1;
            end
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
        idx_d   = 7'd0;
      end
    endcase

`ifdef IRIG_FRAME_TIMEOUT_EN
    if (wd_hit) frame_err = 1'b1;
`endif

    if (frame_err) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      locked_d = 1'b0;
      good_d   = '0;
      state_d  = ST_HUNT;
      idx_d    = 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      idx_q    <= '0;
      cap_q    <= '0;
      fdata_q  <= '0;
      fvld_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= '0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      fdata_q  <= fdata_d;
      fvld_q   <= fvld_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      good_q   <= good_d;
    end
  end

  assign bus.frame_vld  = fvld_q;
  assign bus.frame_data = fdata_q;
  assign bus.locked     = locked_q;
  assign bus.state      = state_q;
  assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_irig_frame_ctrl.sv
// Directed bench for irig_frame_ctrl: symbol-level vector table plus frame, error, stall and reset sequences.
module tb_irig_frame_ctrl;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] SP = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  localparam logic [1:0] HUNT = 2'b00;
  localparam logic [1:0] ARM  = 2'b01;
  localparam logic [1:0] RECV = 2'b10;

  typedef struct {
    logic [1:0] typ;
    logic [1:0] exp_state;
    logic [7:0] exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irig_frame_if bus();

  irig_frame_ctrl #(.LOCK_FRAMES(2), .TIMEOUT_CYC(1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int fv_count = 0;
  logic lock_at_fv = 1'b0;
  logic prev_lock_at_fv = 1'b0;
  logic prev_locked = 1'b0;
  logic [99:0] exp_q[$];
  logic [99:0] mark_mask;
  logic [99:0] d1, d2, d3;
  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame scoreboard: every frame_vld must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && bus.frame_vld) begin
      fv_count++;
      lock_at_fv      = bus.locked;
      prev_lock_at_fv = prev_locked;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_frame actual=%0h required=none", bus.frame_data);
      end else begin
        check("sb_frame", bus.frame_data, exp_q.pop_front());
      end
    end
    prev_locked = bus.locked;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic send_sym(input logic [1:0] t);
    @(negedge clk);
    bus.sym_vld  = 1'b1;
    bus.sym_type = t;
    @(negedge clk);
    bus.sym_vld  = 1'b0;
    bus.sym_type = SP;
  endtask

  function automatic logic [1:0] sym_at(input int i, input logic [99:0] d);
    if (mark_mask[i]) return SP;
    return d[i] ? S1 : S0;
  endfunction

  // Sends indices lo..hi of frame d; tallies any cycle that left RECV.
  task automatic send_range(input logic [99:0] d, input int lo, input int hi, output int off_recv);
    off_recv = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i == 99) exp_q.push_back(d & ~mark_mask);
      send_sym(sym_at(i, d));
      if (bus.state !== RECV) off_recv++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, bus.state, HUNT);
    check({tag, "_locked"}, bus.locked, 1'b0);
    check({tag, "_err"}, bus.err_cnt, 8'd0);
    check({tag, "_fvld"}, bus.frame_vld, 1'b0);
    check({tag, "_fdata"}, bus.frame_data, 100'd0);
  endtask

  initial begin
    int off;
    int fv_before;
    int marks[11] = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};

    bus.sym_vld  = 1'b0;
    bus.sym_type = S0;
    mark_mask = '0;
    foreach (marks[k]) mark_mask[marks[k]] = 1'b1;

    d1 = '0;
    d1[1] = 1'b1; d1[9] = 1'b1; d1[50] = 1'b1; d1[98] = 1'b1;
    d2 = 100'hA5A5A5A5A5A5A5A5A5A5A5A5A;
    d3 = ~d2;

    // Symbol-by-symbol walk of HUNT/ARM/RECV transitions and error paths.
    tbl.push_back('{S0, HUNT, 8'd0});
    tbl.push_back('{SX, HUNT, 8'd0});
    tbl.push_back('{SP, ARM,  8'd0});
    tbl.push_back('{S1, HUNT, 8'd0});
    tbl.push_back('{SP, ARM,  8'd0});
    tbl.push_back('{SX, HUNT, 8'd0});
    tbl.push_back('{SP, ARM,  8'd0});
    tbl.push_back('{SP, RECV, 8'd0});
    tbl.push_back('{S0, RECV, 8'd0});
    tbl.push_back('{S1, RECV, 8'd0});
    tbl.push_back('{SP, HUNT, 8'd1});
    tbl.push_back('{SP, ARM,  8'd1});
    tbl.push_back('{SP, RECV, 8'd1});
    tbl.push_back('{SX, HUNT, 8'd2});
    tbl.push_back('{SP, ARM,  8'd2});
    tbl.push_back('{SP, RECV, 8'd2});
    for (int i = 1; i <= 8; i++) tbl.push_back('{S0, RECV, 8'd2});
    tbl.push_back('{S1, HUNT, 8'd3});

    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    for (int v = 0; v < tbl.size(); v++) begin
      send_sym(tbl[v].typ);
      #1;
      check($sformatf("vec%0d_state", v), bus.state, tbl[v].exp_state);
      check($sformatf("vec%0d_err", v), bus.err_cnt, tbl[v].exp_err);
    end

    // sym_type must be ignored while sym_vld is low (idle drives P).
    repeat (5) @(negedge clk);
    #1 check("idle_hunt_state", bus.state, HUNT);
    send_sym(SP);
    send_sym(SP);
    bus.sym_type = SX;
    repeat (5) @(negedge clk);
    #1;
    check("idle_recv_state", bus.state, RECV);
    check("idle_recv_err", bus.err_cnt, 8'd3);

    do_reset();
    #1 check_reset_vals("rst2");

    // First frame after P,P.
    send_sym(SP);
    send_sym(SP);
    fv_before = fv_count;
    send_range(d1, 1, 99, off);
    #1;
    check("f1_fvld_count", fv_count, fv_before + 1);
    check("f1_bit1", bus.frame_data[1], 1'b1);
    check("f1_bit0", bus.frame_data[0], 1'b0);
    check("f1_marker9", bus.frame_data[9], 1'b0);
    check("f1_locked", bus.locked, 1'b0);
    check("f1_lock_at_fv", lock_at_fv, 1'b0);
    check("f1_in_recv", off, 0);
    @(negedge clk);
    #1 check("f1_fvld_one_cycle", bus.frame_vld, 1'b0);

    // Second frame back-to-back: lock rises with its frame_vld.
    fv_before = fv_count;
    send_range(d2, 0, 99, off);
    #1;
    check("f2_fvld_count", fv_count, fv_before + 1);
    check("f2_lock_at_fv", lock_at_fv, 1'b1);
    check("f2_lock_prev", prev_lock_at_fv, 1'b0);
    check("f2_in_recv", off, 0);
    check("f2_state", bus.state, RECV);

    // While locked, a "0" at marker 49 is a frame error.
    fv_before = fv_count;
    send_range(d3, 0, 48, off);
    send_sym(S0);
    #1;
    check("e49_err", bus.err_cnt, 8'd1);
    check("e49_locked", bus.locked, 1'b0);
    check("e49_state", bus.state, HUNT);
    check("e49_fdata", bus.frame_data, d2 & ~mark_mask);
    check("e49_no_fvld", fv_count, fv_before);

    // Reset at index 50 clears everything at once; then decode resumes.
    send_sym(SP);
    send_sym(SP);
    send_range(d3, 1, 49, off);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_sym(SP);
    send_sym(SP);
    fv_before = fv_count;
    send_range(d3, 1, 99, off);
    #1;
    check("f3_fvld_count", fv_count, fv_before + 1);
    check("f3_fdata", bus.frame_data, d3 & ~mark_mask);
    check("f3_locked", bus.locked, 1'b0);

    // Stalled stream mid-frame.
    send_range(d1, 0, 5, off);
    repeat (1100) @(negedge clk);
    #1;
`ifdef IRIG_FRAME_TIMEOUT_EN
    check("stall_state", bus.state, HUNT);
    check("stall_err", bus.err_cnt, 8'd1);
`else
    check("stall_state", bus.state, RECV);
    check("stall_err", bus.err_cnt, 8'd0);
`endif

    // Error counter saturation.
    do_reset();
    for (int n = 1; n <= 260; n++) begin
      send_sym(SP);
      send_sym(SP);
      send_sym(SP);
      if (n == 254) begin
        #1 check("sat_254", bus.err_cnt, 8'd254);
      end
    end
    #1;
    check("sat_255", bus.err_cnt, 8'd255);
    check("sat_state", bus.state, HUNT);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
